// File: rtl/mips_bard_pkg.sv
// Shared decode constants, control enums and ALU helper for the mips_bard core.
// The optional data memory is enabled by defining MIPS_BARD_DMEM_EN.
package mips_bard_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_SLL = 6'h00;
   localparam logic [5:0] FN_SRL = 6'h02;
   localparam logic [5:0] FN_JR  = 6'h08;
   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_SLT = 6'h2A;

   typedef enum logic [2:0] {
      AluAdd, AluSub, AluAnd, AluOr, AluSlt, AluSll, AluSrl, AluLui
   } alu_op_e;

   typedef enum logic [2:0] {
      WbAlu, WbMem, WbRt, WbLink, WbZero
   } wb_sel_e;

   // Shifts act on b (rt); lui takes the raw immediate in b[15:0].
   function automatic logic [31:0] alu_calc(input alu_op_e op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [4:0] shamt);
      logic [31:0] res;
      case (op)
         AluAdd:  res = a + b;
         AluSub:  res = a - b;
         AluAnd:  res = a & b;
         AluOr:   res = a | b;
         AluSlt:  res = {31'd0, ($signed(a) < $signed(b))};
         AluSll:  res = b << shamt;
         AluSrl:  res = b >> shamt;
         AluLui:  res = {b[15:0], 16'h0000};
         default: res = '0;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/mips_bard_regfile.sv
// 32x32 register file: two combinational read ports, one write port, $0 hardwired to zero.
module mips_bard_regfile (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        we_i,
   input  logic [4:0]  waddr_i,
   input  logic [31:0] wdata_i,
   input  logic [4:0]  raddr_a_i,
   input  logic [4:0]  raddr_b_i,
   output logic [31:0] rdata_a_o,
   output logic [31:0] rdata_b_o
);

   logic [31:0] regs_q [32];

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < 32; i++) regs_q[i] <= '0;
      end else if (we_i && (waddr_i != 5'd0)) begin
         regs_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_a_o = (raddr_a_i == 5'd0) ? '0 : regs_q[raddr_a_i];
   assign rdata_b_o = (raddr_b_i == 5'd0) ? '0 : regs_q[raddr_b_i];

endmodule

// File: rtl/mips_bard_core.sv
// Single-cycle MIPS-I subset core: decode, ALU, next-pc and optional data memory.
// Define MIPS_BARD_DMEM_EN to build the data memory and enable lw/sw.
module mips_bard_core
   import mips_bard_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = 32'h1000_0000,
   parameter int unsigned DMEM_WORDS = 256
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] instruction,
   output logic [31:0] pc,
   output logic [31:0] data_out
);

   logic [31:0] pc_q, pc_d, data_q, data_d;
   logic [5:0]  opcode, funct;
   logic [4:0]  rs, rt, rd, shamt;
   logic [31:0] imm_sext, imm_zext, rs_val, rt_val, alu_b, alu_res, mem_rdata, pc_plus4;
   alu_op_e     alu_op;
   wb_sel_e     wb_sel;
   logic        use_imm, zext, rf_we, mem_we, is_beq, is_bne, is_j, is_jr;
   logic [4:0]  rf_waddr;

   assign opcode   = instruction[31:26];
   assign rs       = instruction[25:21];
   assign rt       = instruction[20:16];
   assign rd       = instruction[15:11];
   assign shamt    = instruction[10:6];
   assign funct    = instruction[5:0];
   assign imm_sext = {{16{instruction[15]}}, instruction[15:0]};
   assign imm_zext = {16'h0000, instruction[15:0]};
   assign pc_plus4 = pc_q + 32'd4;

   mips_bard_regfile u_regfile (
      .clk_i     (clk),
      .rst_i     (rst),
      .we_i      (rf_we),
      .waddr_i   (rf_waddr),
      .wdata_i   (data_d),
      .raddr_a_i (rs),
      .raddr_b_i (rt),
      .rdata_a_o (rs_val),
      .rdata_b_o (rt_val)
   );

   always_comb begin
      alu_op   = AluAdd;
      wb_sel   = WbZero;
      use_imm  = 1'b0;
      zext     = 1'b0;
      rf_we    = 1'b0;
      rf_waddr = rd;
      mem_we   = 1'b0;
      is_beq   = 1'b0;
      is_bne   = 1'b0;
      is_j     = 1'b0;
      is_jr    = 1'b0;
      case (opcode)
         OP_RTYPE: begin
            rf_we  = 1'b1;
            wb_sel = WbAlu;
            case (funct)
               FN_ADD:  alu_op = AluAdd;
               FN_SUB:  alu_op = AluSub;
               FN_AND:  alu_op = AluAnd;
               FN_OR:   alu_op = AluOr;
               FN_SLT:  alu_op = AluSlt;
               FN_SLL:  alu_op = AluSll;
               FN_SRL:  alu_op = AluSrl;
               FN_JR: begin
                  is_jr  = 1'b1;
                  rf_we  = 1'b0;
                  wb_sel = WbZero;
               end
               default: begin
                  rf_we  = 1'b0;
                  wb_sel = WbZero;
               end
            endcase
         end
         OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_LUI: begin
            use_imm  = 1'b1;
            rf_we    = 1'b1;
            rf_waddr = rt;
            wb_sel   = WbAlu;
            case (opcode)
               OP_SLTI: alu_op = AluSlt;
               OP_ANDI: begin alu_op = AluAnd; zext = 1'b1; end
               OP_ORI:  begin alu_op = AluOr;  zext = 1'b1; end
               OP_LUI:  alu_op = AluLui;
               default: alu_op = AluAdd;
            endcase
         end
`ifdef MIPS_BARD_DMEM_EN
         OP_LW: begin
            use_imm  = 1'b1;
            rf_we    = 1'b1;
            rf_waddr = rt;
            wb_sel   = WbMem;
         end
         OP_SW: begin
            use_imm = 1'b1;
            mem_we  = 1'b1;
            wb_sel  = WbRt;
         end
`endif
         OP_BEQ: is_beq = 1'b1;
         OP_BNE: is_bne = 1'b1;
         OP_J:   is_j   = 1'b1;
         OP_JAL: begin
            is_j     = 1'b1;
            rf_we    = 1'b1;
            rf_waddr = 5'd31;
            wb_sel   = WbLink;
         end
         default: ;
      endcase
   end

   assign alu_b   = use_imm ? (zext ? imm_zext : imm_sext) : rt_val;
   assign alu_res = alu_calc(alu_op, rs_val, alu_b, shamt);

`ifdef MIPS_BARD_DMEM_EN
   localparam int unsigned DmemAw = $clog2(DMEM_WORDS);
   logic [31:0]       dmem_q [DMEM_WORDS];
   logic [DmemAw-1:0] dmem_idx;

   assign dmem_idx  = alu_res[DmemAw+1:2];
   assign mem_rdata = dmem_q[dmem_idx];

   // Contents survive reset; reset only suppresses the in-flight store.
   always_ff @(posedge clk) begin
      if (mem_we && !rst) dmem_q[dmem_idx] <= rt_val;
   end
`else
   assign mem_rdata = '0;
`endif

   always_comb begin
      case (wb_sel)
         WbAlu:   data_d = alu_res;
         WbMem:   data_d = mem_rdata;
         WbRt:    data_d = rt_val;
         WbLink:  data_d = pc_plus4;
         default: data_d = '0;
      endcase
   end

   always_comb begin
      pc_d = pc_plus4;
      if ((is_beq && (rs_val == rt_val)) || (is_bne && (rs_val != rt_val))) begin
         pc_d = pc_plus4 + {imm_sext[29:0], 2'b00};
      end else if (is_j) begin
         pc_d = {pc_plus4[31:28], instruction[25:0], 2'b00};
      end else if (is_jr) begin
         pc_d = rs_val;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q   <= RESET_PC;
         data_q <= '0;
      end else begin
         pc_q   <= pc_d;
         data_q <= data_d;
      end
   end

   assign pc       = pc_q;
   assign data_out = data_q;

endmodule

// File: tb/tb_mips_bard_core.sv
// Self-checking bench: directed scenarios plus random instructions against an ISA-level model.
module tb_mips_bard_core;

   localparam logic [31:0] RstPc = 32'h1000_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] instruction = 32'h0;
   logic [31:0] pc, data_out;

   int checks = 0;
   int errors = 0;

   logic [31:0] m_regs [32];
   logic [31:0] m_mem  [256];
   logic [31:0] m_pc, m_dout;

   mips_bard_core dut (
      .clk         (clk),
      .rst         (rst),
      .instruction (instruction),
      .pc          (pc),
      .data_out    (data_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic void model_reset();
      for (int i = 0; i < 32; i++) m_regs[i] = '0;
      m_pc   = RstPc;
      m_dout = '0;
   endfunction

   // Architectural effect of one instruction, straight from the ISA rules.
   function automatic void model_exec(input logic [31:0] ins);
      logic [31:0] a, b, se, ze, npc, res, addr;
      int          wr;
      a   = m_regs[ins[25:21]];
      b   = m_regs[ins[20:16]];
      se  = {{16{ins[15]}}, ins[15:0]};
      ze  = {16'h0, ins[15:0]};
      npc = m_pc + 4;
      res = 0;
      wr  = -1;
      case (ins[31:26])
         6'h00: case (ins[5:0])
            6'h20: begin res = a + b; wr = ins[15:11]; end
            6'h22: begin res = a - b; wr = ins[15:11]; end
            6'h24: begin res = a & b; wr = ins[15:11]; end
            6'h25: begin res = a | b; wr = ins[15:11]; end
            6'h2A: begin res = ($signed(a) < $signed(b)) ? 1 : 0; wr = ins[15:11]; end
            6'h00: begin res = b << ins[10:6]; wr = ins[15:11]; end
            6'h02: begin res = b >> ins[10:6]; wr = ins[15:11]; end
            6'h08: npc = a;
            default: ;
         endcase
         6'h08: begin res = a + se; wr = ins[20:16]; end
         6'h0A: begin res = ($signed(a) < $signed(se)) ? 1 : 0; wr = ins[20:16]; end
         6'h0C: begin res = a & ze; wr = ins[20:16]; end
         6'h0D: begin res = a | ze; wr = ins[20:16]; end
         6'h0F: begin res = ze * 65536; wr = ins[20:16]; end
`ifdef MIPS_BARD_DMEM_EN
         6'h23: begin addr = a + se; res = m_mem[addr[9:2]]; wr = ins[20:16]; end
         6'h2B: begin addr = a + se; m_mem[addr[9:2]] = b; res = b; end
`endif
         6'h04: if (a == b) npc = npc + se * 4;
         6'h05: if (a != b) npc = npc + se * 4;
         6'h02: npc = {npc[31:28], ins[25:0], 2'b00};
         6'h03: begin npc = {npc[31:28], ins[25:0], 2'b00}; res = m_pc + 4; wr = 31; end
         default: ;
      endcase
      if (wr > 0) m_regs[wr] = res;
      m_dout = res;
      m_pc   = npc;
   endfunction

   task automatic step(input logic [31:0] ins, input string tag);
      instruction = ins;
      #1;
      chk({tag, "_hold"}, pc, m_pc);
      model_exec(ins);
      @(posedge clk);
      #1;
      chk({tag, "_pc"}, pc, m_pc);
      chk({tag, "_dout"}, data_out, m_dout);
   endtask

   task automatic reset_cycles(input int n);
      rst = 1'b1;
      model_reset();
      for (int i = 0; i < n; i++) begin
         instruction = $urandom;
         @(posedge clk);
         #1;
         chk("rst_pc", pc, RstPc);
         chk("rst_dout", data_out, 32'h0);
      end
      rst = 1'b0;
   endtask

   function automatic logic [31:0] gen_instr();
      logic [4:0]  rs, rt, rd, sh;
      logic [15:0] imm;
      logic [31:0] ins;
      rs  = 5'($urandom_range(0, 7));
      rt  = 5'($urandom_range(0, 7));
      rd  = 5'($urandom_range(0, 7));
      sh  = 5'($urandom);
      imm = 16'($urandom);
      case ($urandom_range(0, 19))
         0:  ins = {6'h00, rs, rt, rd, 5'd0, 6'h20};
         1:  ins = {6'h00, rs, rt, rd, 5'd0, 6'h22};
         2:  ins = {6'h00, rs, rt, rd, 5'd0, 6'h24};
         3:  ins = {6'h00, rs, rt, rd, 5'd0, 6'h25};
         4:  ins = {6'h00, rs, rt, rd, 5'd0, 6'h2A};
         5:  ins = {6'h00, 5'd0, rt, rd, sh, 6'h00};
         6:  ins = {6'h00, 5'd0, rt, rd, sh, 6'h02};
         7:  ins = {6'h00, rs, 15'd0, 6'h08};
         8:  ins = {6'h08, rs, rt, imm};
         9:  ins = {6'h0A, rs, rt, imm};
         10: ins = {6'h0C, rs, rt, imm};
         11: ins = {6'h0D, rs, rt, imm};
         12: ins = {6'h0F, 5'd0, rt, imm};
         13: ins = {6'h23, rs, rt, imm};
         14: ins = {6'h2B, rs, rt, imm};
         15: ins = {6'h04, rs, rt, imm};
         16: ins = {6'h05, rs, rt, imm};
         17: ins = {5'b00001, 1'($urandom), 26'($urandom)};
         18: ins = {6'h3F, 26'($urandom)};
         default: ins = {6'h00, rs, rt, rd, sh, 6'h3F};
      endcase
      return ins;
   endfunction

   initial begin
      for (int i = 0; i < 256; i++) m_mem[i] = '0;
      reset_cycles(5);

      step(32'h1000_0000, "beq0");
      step(32'h2000_0000, "addi0");
      step(32'h3000_0000, "andi0");
      step(32'h2001_0005, "addi1");
      chk("addi1_val", data_out, 32'd5);
      step(32'h0021_1020, "add2");
      chk("add2_val", data_out, 32'd10);
`ifdef MIPS_BARD_DMEM_EN
      step(32'hAC02_0004, "sw");
      chk("sw_val", data_out, 32'd10);
      step(32'h8C03_0004, "lw");
      chk("lw_val", data_out, 32'd10);
`else
      step(32'h8C03_0004, "lw_nop");
      chk("lw_nop_val", data_out, 32'd0);
`endif
      step(32'h1420_FFFF, "bne_self");
      step(32'h0800_0010, "j");
      chk("j_target", pc, 32'h1000_0040);
      step(32'h2000_0007, "addi_r0");
      chk("addi_r0_val", data_out, 32'd7);
      step(32'h0000_2020, "add_r0");
      chk("add_r0_val", data_out, 32'd0);
      step(32'h0C00_0100, "jal");
      step(32'h03E0_0008, "jr31");
      step(32'h3C06_8000, "lui");
      step(32'h00C0_382A, "slt_neg");

`ifdef MIPS_BARD_DMEM_EN
      for (int k = 0; k < 256; k++) begin
         logic [15:0] off;
         off = 16'(k * 4);
         step({6'h08, 5'd0, 5'd5, 16'($urandom)}, "fill_val");
         step({6'h2B, 5'd0, 5'd5, off}, "fill_sw");
      end
`endif

      for (int n = 0; n < 600; n++) step(gen_instr(), "rand");

      // Reset mid-program must discard the in-flight write.
      rst = 1'b1;
      instruction = 32'h2001_0009;
      model_reset();
      @(posedge clk);
      #1;
      chk("midrst_pc", pc, RstPc);
      chk("midrst_dout", data_out, 32'h0);
      rst = 1'b0;
      step(32'h0021_3020, "post_rst_add");
`ifdef MIPS_BARD_DMEM_EN
      step(32'h8C07_0004, "mem_kept");
`endif

      for (int n = 0; n < 300; n++) step(gen_instr(), "rand2");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
